// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// rtc_read_sequencer: sweeps nine RTC time registers into the display bank,
// with a per-read acknowledge timeout.
// Revision: 1.0
// ============================================================================
module rtc_read_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_data,
  output logic       En,
  output logic [3:0] sel_reg,
  output logic [7:0] data_save,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int             CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]     IDX_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic             ack_hit;
  logic             to_hit;

  // An acknowledge in the final wait cycle takes priority over the timeout.
  assign ack_hit = (state == REQ) && rd_ack;
  assign to_hit  = (state == REQ) && !rd_ack && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // WRITE doubles as the post-read slot for both the En and err pulses.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = REQ;
      REQ:     if (ack_hit || to_hit) state_nxt = WRITE;
      WRITE:   state_nxt = (idx == IDX_LAST) ? DONE : REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx       <= 4'd0;
      cnt       <= '0;
      En        <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      sel_reg   <= 4'd0;
      data_save <= 8'h00;
    end else begin
      En   <= ack_hit;
      err  <= to_hit;
      done <= (state == WRITE) && (idx == IDX_LAST);
      cnt  <= (state == REQ) ? cnt + 1'b1 : '0;
      if (state == IDLE && start) begin
        idx <= 4'd0;
      end else if (state == WRITE && idx != IDX_LAST) begin
        idx <= idx + 4'd1;
      end
      if (ack_hit) begin
        data_save <= rd_data;
        sel_reg   <= idx;
      end
    end
  end

  always_comb begin
    rd_addr = 8'h00;
    if (state == REQ) begin
      case (idx)
        4'd0:    rd_addr = 8'h21;
        4'd1:    rd_addr = 8'h22;
        4'd2:    rd_addr = 8'h23;
        4'd3:    rd_addr = 8'h24;
        4'd4:    rd_addr = 8'h25;
        4'd5:    rd_addr = 8'h26;
        4'd6:    rd_addr = 8'h41;
        4'd7:    rd_addr = 8'h42;
        4'd8:    rd_addr = 8'h43;
        default: rd_addr = 8'h00;
      endcase
    end
  end

  assign rd_req = (state == REQ);
  assign busy   = (state == REQ) || (state == WRITE);

endmodule
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
// ============================================================================
// tb_rtc_read_sequencer: scoreboard bench with a behavioural RTC responder.
// Revision: 1.0
// ============================================================================
module tb_rtc_read_sequencer;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic       En;
  logic [3:0] sel_reg;
  logic [7:0] data_save;
  logic       busy;
  logic       done;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] data;
  } wr_t;

  wr_t        sb[$];
  logic [7:0] addr_map [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

  always #5 clk = ~clk;

  rtc_read_sequencer #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .En        (En),
    .sel_reg   (sel_reg),
    .data_save (data_save),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check(tag, {7'd0, rd_req, rd_addr, En, sel_reg, data_save, busy, done, err}, 32'd0);
  endtask

  // One full sweep. dly: REQ cycles before ack; no_ack: index never acked;
  // spam: extra start pulses mid-sweep and in the DONE cycle; stray: acks
  // and junk data outside REQ; abort_en: assert reset after that many En.
  task automatic sweep(input int dly, input int no_ack, input bit lat,
                       input bit spam, input bit stray, input int abort_en);
    int         cyc = 0;
    int         busy_cyc = 0;
    int         n_en = 0;
    int         n_err = 0;
    int         n_done = 0;
    int         cur = -1;
    int         wcnt = 0;
    bit         in_req = 1'b0;
    bit         fin = 1'b0;
    logic [7:0] hold_addr = 8'h00;
    wr_t        e;
    sb.delete();
    @(negedge clk);
    start  = 1'b1;
    rd_ack = 1'b0;
    @(negedge clk);
    while (!fin) begin
      cyc++;
      start = 1'b0;
      if (spam && (cyc == 3 || cyc == 10)) start = 1'b1;
      if (busy) busy_cyc++;
      if (En || err || done) check("strobe_onehot", $countones({En, err, done}), 1);
      if (En) begin
        n_en++;
        if (sb.size() == 0) begin
          check("en_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sel_reg", sel_reg, e.sel);
          check("data_save", data_save, e.data);
        end
      end
      if (err) begin
        n_err++;
        check("err_idx", cur, no_ack);
      end
      if (done) begin
        n_done++;
        fin = 1'b1;
        check("busy_at_done", busy, 0);
        if (lat) begin
          check("latency", cyc, 19);
          check("busy_cycles", busy_cyc, 18);
        end
        if (spam) start = 1'b1;
      end
      if (abort_en > 0 && n_en == abort_en) begin
        rd_ack = 1'b0;
        start  = 1'b0;
        #2 reset = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk);
        #1 check_zero("reset_held");
        @(negedge clk);
        reset = 1'b1;
        #1 check_zero("reset_release");
        sb.delete();
        return;
      end
      rd_ack  = 1'b0;
      rd_data = stray ? 8'($urandom) : 8'h00;
      if (rd_req) begin
        if (!in_req) begin
          in_req    = 1'b1;
          cur++;
          wcnt      = 0;
          hold_addr = rd_addr;
          if (cur > 8) check("extra_req", cur, 8);
          else         check("rd_addr", rd_addr, addr_map[cur]);
        end else if (rd_addr !== hold_addr) begin
          check("rd_addr_stable", rd_addr, hold_addr);
        end
        if (wcnt == dly && cur != no_ack) begin
          rd_ack  = 1'b1;
          rd_data = 8'(8'h10 + cur);
          sb.push_back('{sel: 4'(cur), data: 8'(8'h10 + cur)});
        end
        wcnt++;
      end else begin
        if (in_req && cur == no_ack) check("timeout_len", wcnt, TO);
        in_req = 1'b0;
        if (stray && !fin) rd_ack = 1'($urandom_range(0, 1));
      end
      if (cyc > 400) begin
        check("cycle_budget", cyc, 0);
        fin = 1'b1;
      end
      @(negedge clk);
    end
    rd_ack = 1'b0;
    start  = 1'b0;
    check("en_count", n_en, (no_ack >= 0) ? 8 : 9);
    check("err_count", n_err, (no_ack >= 0) ? 1 : 0);
    check("done_count", n_done, 1);
    check("sb_empty", sb.size(), 0);
    for (int i = 0; i < 3; i++) begin
      check("idle_after", {busy, rd_req, En}, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    rd_ack  = 1'b0;
    rd_data = 8'h00;
    #1 check_zero("por");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sweep(2, -1, 1'b0, 1'b0, 1'b0, 0);
    sweep(0, -1, 1'b1, 1'b0, 1'b0, 0);
    sweep(1,  3, 1'b0, 1'b0, 1'b0, 0);
    sweep(0, -1, 1'b0, 1'b1, 1'b1, 0);
    sweep(1, -1, 1'b0, 1'b0, 1'b0, 5);
    sweep(0, -1, 1'b1, 1'b0, 1'b0, 0);
    sweep(TO - 1, -1, 1'b0, 1'b0, 1'b0, 0);
    sweep(2,  8, 1'b0, 1'b0, 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
